// File: rtl/adc_pkg.sv
// adc_pkg: shared definitions for the ADC sequencer slice.
//   - ST_* state encodings for the conversion FSM
//   - DATA_W_DEF: default ADC data width
//   - clog2/max3: constant helpers for sizing counters
package adc_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_WAIT_INT = 3'd2,
    ST_SETTLE   = 3'd3,
    ST_CAPTURE  = 3'd4
  } adc_state_e;

  // Bits needed to hold 0..n-1. Never returns less than 1, so a counter
  // sized with it is always a legal vector.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/adc_seq_ctrl_if.sv
// adc_seq_ctrl_if: ADC pins plus the control/result bus of adc_seq_ctrl.
//   en, err_clr         run enable and error clear from the host
//   INT, DB             ADC end-of-conversion (falling edge) and data bus
//   WR                  active-low start-conversion strobe to the ADC
//   tick                conversion period pulse
//   sample/sample_valid raw capture and its one-cycle strobe
//   avg/avg_valid       boxcar average and its one-cycle strobe
//   timeout_err         sticky conversion-timeout flag
// master: the sequencer side. slave: the ADC/host side.
interface adc_seq_ctrl_if #(
  parameter int DATA_W = adc_pkg::DATA_W_DEF
);

  logic              en;
  logic              err_clr;
  logic              INT;
  logic [DATA_W-1:0] DB;
  logic              WR;
  logic              tick;
  logic [DATA_W-1:0] sample;
  logic              sample_valid;
  logic [DATA_W-1:0] avg;
  logic              avg_valid;
  logic              timeout_err;

  modport master (
    input  en, err_clr, INT, DB,
    output WR, tick, sample, sample_valid, avg, avg_valid, timeout_err
  );

  modport slave (
    output en, err_clr, INT, DB,
    input  WR, tick, sample, sample_valid, avg, avg_valid, timeout_err
  );

endinterface

// File: rtl/adc_tick_gen.sv
// adc_tick_gen: free-running 0..TICK_DIV-1 counter with a one-cycle tick.
//   clk, rst  clock and asynchronous active-high reset
//   tick      high for one cycle per period, in the last cycle before the
//             counter wraps back to 0
module adc_tick_gen
  import adc_pkg::*;
#(
  parameter int TICK_DIV = 100
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // tick is decoded from the next count so it lines up with cnt_q == LAST
  // while still coming straight out of a flop.
  always_comb begin
    cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    tick_d = (cnt_d == LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/adc_seq_ctrl.sv
// adc_seq_ctrl: periodic conversion sequencer for a parallel-output ADC.
// Each tick (while en) pulses WR low, waits for INT to fall, lets DB settle,
// captures it as a raw sample and folds it into a 2^AVG_LOG2 boxcar average.
// A conversion that never ends sets a sticky timeout_err and drops the
// partial average.
//   clk, rst  clock and asynchronous active-high reset
//   bus       adc_seq_ctrl_if.master (ADC pins, control, results)
module adc_seq_ctrl
  import adc_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int TICK_DIV = 100,
  parameter int WR_PULSE = 4,
  parameter int SETTLE   = 2,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 1000
) (
  input  logic           clk,
  input  logic           rst,
  adc_seq_ctrl_if.master bus
);

  // One phase counter is shared by START, WAIT_INT and SETTLE.
  localparam int PH_W  = clog2(max3(WR_PULSE, TIMEOUT, SETTLE));
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;

  localparam logic [PH_W-1:0]  WR_LAST     = PH_W'(WR_PULSE - 1);
  localparam logic [PH_W-1:0]  TO_LAST     = PH_W'(TIMEOUT - 1);
  localparam logic [PH_W-1:0]  SETTLE_LAST = PH_W'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'((1 << AVG_LOG2) - 1);

  logic tick_w;

  adc_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick_w)
  );

  // Two-flop synchroniser on INT plus one history flop for edge detection.
  // Resetting to 1 means a low INT at reset never looks like a fresh fall
  // inside WAIT_INT.
  logic int_s1_q, int_s2_q, int_prev_q;
  logic int_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_s1_q   <= 1'b1;
      int_s2_q   <= 1'b1;
      int_prev_q <= 1'b1;
    end else begin
      int_s1_q   <= bus.INT;
      int_s2_q   <= int_s1_q;
      int_prev_q <= int_s2_q;
    end
  end

  assign int_fall = int_prev_q & ~int_s2_q;

  adc_state_e        state_q, state_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              sample_valid_q, sample_valid_d;
  logic [DATA_W-1:0] avg_q, avg_d;
  logic              avg_valid_q, avg_valid_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [ACC_W-1:0]  acc_sum;

  always_comb begin
    state_d        = state_q;
    ph_d           = ph_q;
    wr_d           = wr_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    avg_d          = avg_q;
    avg_valid_d    = 1'b0;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    // A timeout in the same cycle overrides this clear further down.
    err_d          = bus.err_clr ? 1'b0 : err_q;
    acc_sum        = acc_q + ACC_W'(bus.DB);

    unique case (state_q)
      ST_IDLE: begin
        if (tick_w && bus.en) begin
          state_d = ST_START;
          wr_d    = 1'b0;
          ph_d    = '0;
        end
      end

      ST_START: begin
        if (ph_q == WR_LAST) begin
          wr_d    = 1'b1;
          ph_d    = '0;
          state_d = ST_WAIT_INT;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end

      // A fall arriving in the very cycle the timer expires still counts
      // as a good conversion.
      ST_WAIT_INT: begin
        if (int_fall) begin
          ph_d    = '0;
          state_d = (SETTLE == 0) ? ST_CAPTURE : ST_SETTLE;
        end else if (ph_q == TO_LAST) begin
          err_d   = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end

      ST_SETTLE: begin
        if (ph_q == SETTLE_LAST) begin
          state_d = ST_CAPTURE;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end

      // DB is sampled raw: the ADC holds it stable from INT fall until the
      // next WR, so no synchroniser is needed on the data path.
      ST_CAPTURE: begin
        sample_d       = bus.DB;
        sample_valid_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          avg_d       = acc_sum[ACC_W-1:AVG_LOG2];
          avg_valid_d = 1'b1;
          acc_d       = '0;
          cnt_d       = '0;
        end else begin
          acc_d = acc_sum;
          cnt_d = cnt_q + 1'b1;
        end
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        wr_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      ph_q           <= '0;
      wr_q           <= 1'b1;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      avg_q          <= '0;
      avg_valid_q    <= 1'b0;
      acc_q          <= '0;
      cnt_q          <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      ph_q           <= ph_d;
      wr_q           <= wr_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      avg_q          <= avg_d;
      avg_valid_q    <= avg_valid_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      err_q          <= err_d;
    end
  end

  assign bus.WR           = wr_q;
  assign bus.tick         = tick_w;
  assign bus.sample       = sample_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.avg          = avg_q;
  assign bus.avg_valid    = avg_valid_q;
  assign bus.timeout_err  = err_q;

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// tb_adc_seq_ctrl: directed self-checking bench for adc_seq_ctrl with
// default parameters. A vector table drives back-to-back conversions;
// hand-written sequences cover timeout, enable drop and mid-start reset.
module tb_adc_seq_ctrl;

  logic clk;
  logic rst;
  int   cyc;
  int   n_vec;
  int   n_miss;

  typedef struct packed {
    logic [7:0]  db;
    logic [15:0] dly;
    logic        exp_av;
    logic [7:0]  exp_avg;
  } vec_t;

  vec_t vecs [0:7];

  adc_seq_ctrl_if #(.DATA_W(8)) bus ();

  adc_seq_ctrl #(
    .DATA_W   (8),
    .TICK_DIV (100),
    .WR_PULSE (4),
    .SETTLE   (2),
    .AVG_LOG2 (2),
    .TIMEOUT  (1000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // cyc == k at the negedge that follows the k-th posedge after reset release
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_vec++;
    if (actual != expected) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One full conversion: waits for the start strobe, lets INT fall `dly`
  // cycles after WR returns high, and records when/what gets captured.
  task automatic applyStimulus(input logic [7:0] db, input int dly, input bit drop_en,
                               output int wr_fall, output int wr_len, output int tick_cyc,
                               output int lat, output int smp, output int av,
                               output int avg, output int pulse_ok);
    int fall;
    wr_fall = -1; wr_len = -1; tick_cyc = -1; lat = -1;
    smp = -1; av = -1; avg = -1; pulse_ok = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.tick) tick_cyc = cyc;
      if (!bus.WR) begin
        wr_fall = cyc;
        break;
      end
    end
    if (wr_fall < 0) return;
    wr_len = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.WR) break;
      wr_len++;
    end
    if (drop_en) bus.en = 1'b0;
    repeat (dly) @(negedge clk);
    bus.DB  = db;
    bus.INT = 1'b0;
    fall    = cyc;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.sample_valid) begin
        lat = cyc - fall;
        smp = int'(bus.sample);
        av  = int'(bus.avg_valid);
        avg = int'(bus.avg);
        @(negedge clk);
        pulse_ok = int'(!bus.sample_valid && !bus.avg_valid);
        break;
      end
    end
    bus.INT = 1'b1;
  endtask

  task automatic checkConversion(input string tag, input int exp_smp, input int exp_av,
                                 input int exp_avg, input int wr_len, input int lat,
                                 input int smp, input int av, input int avg, input int pulse_ok);
    checkOutput($sformatf("%s_wr_len", tag), wr_len, 4);
    checkOutput($sformatf("%s_latency", tag), lat, 6);
    checkOutput($sformatf("%s_sample", tag), smp, exp_smp);
    checkOutput($sformatf("%s_avg_valid", tag), av, exp_av);
    if (exp_av != 0) checkOutput($sformatf("%s_avg", tag), avg, exp_avg);
    checkOutput($sformatf("%s_pulse_width", tag), pulse_ok, 1);
  endtask

  // Starts a conversion that never ends and measures when the error rises.
  task automatic waitTimeout(output int started, output int dt, output int saw_sv);
    int entry;
    started = 0; dt = -1; saw_sv = 0; entry = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!bus.WR) begin
        started = 1;
        break;
      end
    end
    if (started == 0) return;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.WR) begin
        entry = cyc;
        break;
      end
    end
    if (entry < 0) return;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (bus.sample_valid) saw_sv = 1;
      if (bus.timeout_err) begin
        dt = cyc - entry;
        break;
      end
    end
  endtask

  task automatic clearError(input string tag);
    repeat (5) @(negedge clk);
    checkOutput($sformatf("%s_err_sticky", tag), int'(bus.timeout_err), 1);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    checkOutput($sformatf("%s_err_cleared", tag), int'(bus.timeout_err), 0);
  endtask

  initial begin
    int wf, wl, tc, lat, smp, av, avg, pok;
    int started, dt, saw;
    int nt, wr_low, found;

    n_vec = 0;
    n_miss = 0;
    rst = 1'b1;
    bus.en = 1'b1;
    bus.err_clr = 1'b0;
    bus.INT = 1'b1;
    bus.DB = 8'd0;

    vecs[0] = '{db: 8'd10,  dly: 16'd5,  exp_av: 1'b0, exp_avg: 8'd0};
    vecs[1] = '{db: 8'd20,  dly: 16'd7,  exp_av: 1'b0, exp_avg: 8'd0};
    vecs[2] = '{db: 8'd30,  dly: 16'd3,  exp_av: 1'b0, exp_avg: 8'd0};
    vecs[3] = '{db: 8'd41,  dly: 16'd9,  exp_av: 1'b1, exp_avg: 8'd25};
    vecs[4] = '{db: 8'd255, dly: 16'd4,  exp_av: 1'b0, exp_avg: 8'd0};
    vecs[5] = '{db: 8'd255, dly: 16'd12, exp_av: 1'b0, exp_avg: 8'd0};
    vecs[6] = '{db: 8'd255, dly: 16'd6,  exp_av: 1'b0, exp_avg: 8'd0};
    vecs[7] = '{db: 8'd254, dly: 16'd8,  exp_av: 1'b1, exp_avg: 8'd254};

    repeat (3) @(negedge clk);
    checkOutput("rst_WR", int'(bus.WR), 1);
    checkOutput("rst_tick", int'(bus.tick), 0);
    checkOutput("rst_sample", int'(bus.sample), 0);
    checkOutput("rst_sample_valid", int'(bus.sample_valid), 0);
    checkOutput("rst_avg", int'(bus.avg), 0);
    checkOutput("rst_avg_valid", int'(bus.avg_valid), 0);
    checkOutput("rst_timeout_err", int'(bus.timeout_err), 0);
    rst = 1'b0;

    $display("[TB] first conversion after reset");
    applyStimulus(8'h5A, 100, 1'b0, wf, wl, tc, lat, smp, av, avg, pok);
    checkOutput("first_tick_cycle", tc, 99);
    checkOutput("first_wr_fall_cycle", wf, 100);
    checkConversion("first", 'h5A, 0, 0, wl, lat, smp, av, avg, pok);

    $display("[TB] conversion timeout");
    waitTimeout(started, dt, saw);
    checkOutput("to1_started", started, 1);
    checkOutput("to1_cycles", dt, 1000);
    checkOutput("to1_no_sample", saw, 0);
    clearError("to1");

    $display("[TB] vector table");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].db, int'(vecs[i].dly), 1'b0, wf, wl, tc, lat, smp, av, avg, pok);
      checkConversion($sformatf("vec%0d", i), int'(vecs[i].db), int'(vecs[i].exp_av),
                      int'(vecs[i].exp_avg), wl, lat, smp, av, avg, pok);
    end

    $display("[TB] timeout discards partial average");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(8'd200, 5, 1'b0, wf, wl, tc, lat, smp, av, avg, pok);
      checkConversion($sformatf("part%0d", i), 200, 0, 0, wl, lat, smp, av, avg, pok);
    end
    waitTimeout(started, dt, saw);
    checkOutput("to2_started", started, 1);
    checkOutput("to2_cycles", dt, 1000);
    clearError("to2");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'd8, 5, 1'b0, wf, wl, tc, lat, smp, av, avg, pok);
      checkConversion($sformatf("eight%0d", i), 8, (i == 3) ? 1 : 0, 8, wl, lat, smp, av, avg, pok);
    end

    $display("[TB] en dropped during WAIT_INT");
    applyStimulus(8'h77, 10, 1'b1, wf, wl, tc, lat, smp, av, avg, pok);
    checkConversion("endrop", 'h77, 0, 0, wl, lat, smp, av, avg, pok);
    nt = 0;
    wr_low = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!bus.WR) wr_low = 1;
      if (bus.tick) nt++;
      if (nt == 3) break;
    end
    @(negedge clk);
    if (!bus.WR) wr_low = 1;
    checkOutput("endrop_ticks_seen", nt, 3);
    checkOutput("endrop_no_start", wr_low, 0);
    bus.en = 1'b1;

    $display("[TB] reset during START");
    found = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!bus.WR) begin
        found = 1;
        break;
      end
    end
    checkOutput("rst6_start_seen", found, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst6_WR_async", int'(bus.WR), 1);
    checkOutput("rst6_sample", int'(bus.sample), 0);
    checkOutput("rst6_avg", int'(bus.avg), 0);
    checkOutput("rst6_sample_valid", int'(bus.sample_valid), 0);
    checkOutput("rst6_avg_valid", int'(bus.avg_valid), 0);
    checkOutput("rst6_tick", int'(bus.tick), 0);
    checkOutput("rst6_timeout_err", int'(bus.timeout_err), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    applyStimulus(8'h33, 20, 1'b0, wf, wl, tc, lat, smp, av, avg, pok);
    checkOutput("rst6_tick_cycle", tc, 99);
    checkOutput("rst6_wr_fall_cycle", wf, 100);
    checkConversion("rst6", 'h33, 0, 0, wl, lat, smp, av, avg, pok);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/adc_seq_ctrl.md
Name: adc_seq_ctrl

Overview:
Parametrised successor to the single-shot ADC handshake in top. Periodically starts conversions on an external parallel-output ADC through WR, waits for end-of-conversion on INT, and captures DB after a settle delay. Emits each raw sample and a boxcar average over 2^AVG_LOG2 samples. Adds a conversion timeout with a sticky error flag and a run enable. Sits between the ADC pins and downstream processing in top.

Parameters:
DATA_W, 8, width of DB and of the sample/average outputs
TICK_DIV, 100, clk cycles between conversion starts (tick period), >=16
WR_PULSE, 4, clk cycles WR is held low per start, >=1
SETTLE, 2, clk cycles from detected INT fall to DB capture, >=0
AVG_LOG2, 2, log2 of samples per average (0 = pass-through)
TIMEOUT, 1000, max clk cycles in WAIT_INT before abort, >WR_PULSE

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
en  in  1  run enable, sampled on tick
INT  in  1  ADC end-of-conversion, asynchronous; a falling edge means data ready
DB  in  DATA_W  ADC data bus, asynchronous, valid after INT falls
WR  out  1  ADC start-conversion strobe, active low
tick  out  1  one-cycle pulse every TICK_DIV cycles
sample  out  DATA_W  last captured raw sample
sample_valid  out  1  one-cycle pulse when sample updates
avg  out  DATA_W  last completed average
avg_valid  out  1  one-cycle pulse when avg updates
timeout_err  out  1  sticky conversion-timeout flag
err_clr  in  1  clears timeout_err

Behaviour:
- Reset (async assert, sync release): WR=1; tick, sample_valid, avg_valid, timeout_err=0; sample=avg=0; accumulator and sample count=0; FSM=IDLE; tick counter=0.
- Tick: a free-running counter counts 0..TICK_DIV-1. tick pulses when the count wraps. The counter runs regardless of en.
- INT passes through a 2-flop synchroniser. A fall is detected when the synchronised value is 0 and was 1 on the previous cycle. This gives 3 cycles of latency from the pin.
- FSM states and transitions:
  - IDLE: on tick with en=1, go to START.
  - START: WR=0 for exactly WR_PULSE cycles, then WR=1 and go to WAIT_INT.
  - WAIT_INT: on a detected fall, go to SETTLE. If TIMEOUT cycles elapse first, set timeout_err, discard the partial average (clear accumulator and count), and go to IDLE.
  - SETTLE: wait SETTLE cycles, then go to CAPTURE.
  - CAPTURE: register DB into sample and pulse sample_valid for one cycle. Add DB to the accumulator and increment the count. Go to IDLE.
- Averaging:
  - The accumulator is DATA_W+AVG_LOG2 bits wide and cannot overflow.
  - When the count reaches 2^AVG_LOG2: avg = accumulator >> AVG_LOG2 (truncating), avg_valid pulses in the same cycle as that sample's sample_valid, and the accumulator and count clear.
- Ticks arriving outside IDLE are ignored; there is no queuing. An INT fall outside WAIT_INT is ignored.
- Dropping en mid-conversion completes the current conversion; no new start follows.
- If err_clr and a new timeout occur in the same cycle, set wins.
- DB is captured directly, without a synchroniser. The ADC guarantees DB is stable from its INT fall until the next WR.

Decomposition:
- Shared header/package adc_pkg holds:
  - the FSM state encodings (IDLE, START, WAIT_INT, SETTLE, CAPTURE);
  - the default DATA_W;
  - a CLOG2 function for counter widths.
- One natural sub-module, adc_tick_gen: the parametrised TICK_DIV counter with its tick pulse. It is reusable by top's other timing.
- The synchroniser is inline.

Test Plan:
1. Reset release, en=1, defaults: first tick at cycle 99 → WR low cycles 100–103 → bench raises INT, then drops it 100 cycles later with DB=0x5A → sample=0x5A, sample_valid exactly 3+2+1 cycles after the INT pin fall.
2. Four conversions with DB=10, 20, 30, 41 → avg_valid on the 4th capture, avg=25 (101>>2); accumulator cleared and the next avg is independent.
3. INT never falls → timeout_err=1 at WAIT_INT entry+1000; no sample_valid; next tick restarts; err_clr pulse → timeout_err=0.
4. Timeout after 2 of 4 samples (DB=200, 200), then 4 samples of 8 → avg=8, proving the partial accumulator was discarded.
5. en=0 asserted during WAIT_INT → current sample still captured; WR stays high for the following 3 ticks.
6. rst asserted during START → WR=1 immediately (asynchronous); all outputs at reset values; normal operation from the next tick after release.
